// File: rtl/dcache_snoop_responder.sv
// Coherence snoop responder for one dcache: mirrors tags/MSI state, supplies Modified
// blocks word by word on a snoop, and applies the resulting downgrade or invalidate.
module dcache_snoop_responder #(
    parameter int unsigned SETS = 8,
    parameter int unsigned WAYS = 2,
    parameter int unsigned TW   = 26,
    localparam int unsigned IW  = $clog2(SETS)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ccwait,
    input  logic [31:0]   ccsnoopaddr,
    input  logic          ccinv,
    input  logic          dwait,
    output logic          cctrans,
    output logic [31:0]   snoop_daddr,
    output logic [31:0]   snoop_dstore,
    output logic          snoop_busy,
    output logic [IW-1:0] rd_index,
    output logic          rd_way,
    output logic          rd_blkoff,
    input  logic [31:0]   rd_data,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_index,
    input  logic          upd_way,
    input  logic [TW-1:0] upd_tag,
    input  logic [1:0]    upd_state
);

    localparam logic [1:0] LineI = 2'b00;
    localparam logic [1:0] LineS = 2'b01;
    localparam logic [1:0] LineM = 2'b10;

    typedef enum logic [1:0] {StIdle, StWb0, StWb1} fsm_e;

    fsm_e fsm_q, fsm_d;

    logic [TW-1:0] tag_q   [SETS][WAYS];
    logic [1:0]    state_q [SETS][WAYS];

    logic [IW-1:0] snp_index_q;
    logic          snp_way_q;
    logic [TW-1:0] snp_tag_q;
    logic          inv_seen_q;

    logic [IW-1:0] s_index;
    logic [TW-1:0] s_tag;
    logic          match0, match1;
    logic          hit, hit_way;
    logic [1:0]    hit_state;
    logic          accept, s_inv, wb_done, upd_ok;

    assign s_index = ccsnoopaddr[3 +: IW];
    assign s_tag   = ccsnoopaddr[31 -: TW];

    always_comb begin
        match0 = ((state_q[s_index][0] == LineS) || (state_q[s_index][0] == LineM))
                 && (tag_q[s_index][0] == s_tag);
        match1 = ((state_q[s_index][1] == LineS) || (state_q[s_index][1] == LineM))
                 && (tag_q[s_index][1] == s_tag);
        hit       = match0 || match1;
        // Way 0 takes priority if both ways somehow hold the same tag.
        hit_way   = !match0 && match1;
        hit_state = state_q[s_index][hit_way];
    end

    always_comb begin
        fsm_d        = fsm_q;
        cctrans      = 1'b0;
        snoop_busy   = 1'b0;
        snoop_daddr  = '0;
        snoop_dstore = '0;
        rd_index     = '0;
        rd_way       = 1'b0;
        rd_blkoff    = 1'b0;
        accept       = 1'b0;
        s_inv        = 1'b0;
        wb_done      = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                snoop_busy = ccwait;
                if (ccwait && hit) begin
                    if (hit_state == LineM) begin
                        cctrans = 1'b1;
                        accept  = 1'b1;
                        fsm_d   = StWb0;
                    end else if (ccinv) begin
                        s_inv = 1'b1;
                    end
                end
            end
            StWb0, StWb1: begin
                cctrans      = 1'b1;
                snoop_busy   = 1'b1;
                rd_index     = snp_index_q;
                rd_way       = snp_way_q;
                rd_blkoff    = (fsm_q == StWb1);
                snoop_daddr  = {snp_tag_q, snp_index_q, fsm_q == StWb1, 2'b00};
                snoop_dstore = rd_data;
                if (!dwait) begin
                    fsm_d   = (fsm_q == StWb0) ? StWb1 : StIdle;
                    wb_done = (fsm_q == StWb1);
                end
            end
            default: fsm_d = StIdle;
        endcase
        // ccwait may still be high while reset is held; keep the bus quiet.
        if (!nRST) begin
            cctrans    = 1'b0;
            snoop_busy = 1'b0;
        end
    end

    // The line being written back is frozen against local updates until it is downgraded.
    assign upd_ok = upd_en && !((fsm_q != StIdle) && (upd_index == snp_index_q)
                                && (upd_way == snp_way_q));

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            fsm_q       <= StIdle;
            snp_index_q <= '0;
            snp_way_q   <= 1'b0;
            snp_tag_q   <= '0;
            inv_seen_q  <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                snp_index_q <= s_index;
                snp_way_q   <= hit_way;
                snp_tag_q   <= s_tag;
                inv_seen_q  <= ccinv;
            end else if (fsm_q != StIdle) begin
                inv_seen_q <= inv_seen_q | ccinv;
            end
        end
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            tag_q   <= '{default: '0};
            state_q <= '{default: LineI};
        end else begin
            if (upd_ok) begin
                tag_q[upd_index][upd_way]   <= upd_tag;
                state_q[upd_index][upd_way] <= (upd_state == 2'b11) ? LineI : upd_state;
            end
            // Later assignments win: snoop invalidate overrides a same-entry local update.
            if (s_inv) begin
                state_q[s_index][hit_way] <= LineI;
            end
            if (wb_done) begin
                state_q[snp_index_q][snp_way_q] <= (inv_seen_q || ccinv) ? LineI : LineS;
            end
        end
    end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
// Directed self-checking bench for dcache_snoop_responder.
module tb_dcache_snoop_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ccwait, ccinv, dwait;
    logic [31:0] ccsnoopaddr;
    logic        cctrans, snoop_busy;
    logic [31:0] snoop_daddr, snoop_dstore;
    logic [2:0]  rd_index;
    logic        rd_way, rd_blkoff;
    logic [31:0] rd_data;
    logic        upd_en, upd_way;
    logic [2:0]  upd_index;
    logic [25:0] upd_tag;
    logic [1:0]  upd_state;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    // Data array model: each word encodes its own location.
    assign rd_data = 32'hD000_0000 | {27'd0, rd_index, rd_way, rd_blkoff};

    dcache_snoop_responder dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccsnoopaddr(ccsnoopaddr), .ccinv(ccinv),
        .dwait(dwait), .cctrans(cctrans), .snoop_daddr(snoop_daddr),
        .snoop_dstore(snoop_dstore), .snoop_busy(snoop_busy), .rd_index(rd_index),
        .rd_way(rd_way), .rd_blkoff(rd_blkoff), .rd_data(rd_data), .upd_en(upd_en),
        .upd_index(upd_index), .upd_way(upd_way), .upd_tag(upd_tag), .upd_state(upd_state)
    );

    // Inputs change right after a negedge; comparisons happen #1 later.
    task automatic do_upd(input logic [2:0] idx, input logic way, input logic [25:0] tag,
                          input logic [1:0] st);
        upd_en = 1'b1; upd_index = idx; upd_way = way; upd_tag = tag; upd_state = st;
        @(negedge CLK);
        upd_en = 1'b0;
    endtask

    task automatic test_reset;
        nRST = 1'b0; ccwait = 1'b1; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = 32'h40;
        upd_en = 1'b0; upd_index = '0; upd_way = 1'b0; upd_tag = '0; upd_state = '0;
        @(negedge CLK); #1;
        checks++; if (cctrans !== 1'b0) begin failures++; $display("FAIL rst_cctrans got=%0h exp=0", cctrans); end
        checks++; if (snoop_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", snoop_busy); end
        checks++; if ({snoop_daddr, snoop_dstore, rd_index, rd_way, rd_blkoff} !== '0) begin
            failures++; $display("FAIL rst_outs got=%0h/%0h/%0h/%0h/%0h exp=0", snoop_daddr, snoop_dstore, rd_index, rd_way, rd_blkoff); end
        @(negedge CLK);
        nRST = 1'b1; #1;
        checks++; if (cctrans !== 1'b0) begin failures++; $display("FAIL miss_cctrans got=%0h exp=0", cctrans); end
        checks++; if (snoop_busy !== 1'b1) begin failures++; $display("FAIL miss_busy got=%0h exp=1", snoop_busy); end
        @(negedge CLK);
        ccwait = 1'b0; #1;
        checks++; if (dut.state_q[0][1] !== 2'b00) begin failures++; $display("FAIL miss_state got=%0h exp=0", dut.state_q[0][1]); end
        checks++; if (snoop_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0h exp=0", snoop_busy); end
    endtask

    task automatic test_writeback(input logic inv_in_wb1, input logic [1:0] exp_state);
        do_upd(3'd0, 1'b1, 26'h1, 2'b10);
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0; dwait = 1'b1; #1;
        checks++; if (cctrans !== 1'b1) begin failures++; $display("FAIL acc_cctrans got=%0h exp=1", cctrans); end
        @(negedge CLK);
        ccwait = 1'b0; #1;  // ccwait dropping mid-writeback must not abort it
        checks++; if (snoop_daddr !== 32'h40) begin failures++; $display("FAIL wb0_daddr got=%0h exp=40", snoop_daddr); end
        checks++; if (snoop_dstore !== 32'hD000_0002) begin failures++; $display("FAIL wb0_dstore got=%0h exp=d0000002", snoop_dstore); end
        checks++; if ({cctrans, snoop_busy, rd_index, rd_way, rd_blkoff} !== 7'b11_000_10) begin
            failures++; $display("FAIL wb0_ctl got=%0b exp=1100010", {cctrans, snoop_busy, rd_index, rd_way, rd_blkoff}); end
        @(negedge CLK); #1;
        checks++; if ({cctrans, snoop_daddr, snoop_dstore} !== {1'b1, 32'h40, 32'hD000_0002}) begin
            failures++; $display("FAIL wb0_stall got=%0h/%0h/%0h exp=1/40/d0000002", cctrans, snoop_daddr, snoop_dstore); end
        dwait = 1'b0;
        @(negedge CLK);
        ccinv = inv_in_wb1; #1;
        checks++; if (snoop_daddr !== 32'h44) begin failures++; $display("FAIL wb1_daddr got=%0h exp=44", snoop_daddr); end
        checks++; if (snoop_dstore !== 32'hD000_0003) begin failures++; $display("FAIL wb1_dstore got=%0h exp=d0000003", snoop_dstore); end
        checks++; if ({cctrans, rd_blkoff} !== 2'b11) begin failures++; $display("FAIL wb1_ctl got=%0b exp=11", {cctrans, rd_blkoff}); end
        @(negedge CLK);
        ccinv = 1'b0; dwait = 1'b1; #1;
        checks++; if ({cctrans, snoop_busy, snoop_daddr} !== '0) begin
            failures++; $display("FAIL wb_idle got=%0h/%0h/%0h exp=0", cctrans, snoop_busy, snoop_daddr); end
        checks++; if (dut.state_q[0][1] !== exp_state) begin failures++; $display("FAIL wb_final_state got=%0h exp=%0h", dut.state_q[0][1], exp_state); end
        ccwait = 1'b1; ccsnoopaddr = 32'h40; #1;
        checks++; if (cctrans !== 1'b0) begin failures++; $display("FAIL resnoop_cctrans got=%0h exp=0", cctrans); end
        @(negedge CLK);
        ccwait = 1'b0;
    endtask

    task automatic test_s_invalidate;
        do_upd(3'd2, 1'b0, 26'h3, 2'b01);
        ccwait = 1'b1; ccsnoopaddr = 32'hD0; ccinv = 1'b0; #1;
        checks++; if ({cctrans, snoop_busy} !== 2'b01) begin failures++; $display("FAIL s_hit got=%0b exp=01", {cctrans, snoop_busy}); end
        @(negedge CLK); #1;
        checks++; if (dut.state_q[2][0] !== 2'b01) begin failures++; $display("FAIL s_noinv_state got=%0h exp=1", dut.state_q[2][0]); end
        ccinv = 1'b1; #1;
        checks++; if (cctrans !== 1'b0) begin failures++; $display("FAIL s_inv_cctrans got=%0h exp=0", cctrans); end
        @(negedge CLK);
        ccinv = 1'b0; #1;
        checks++; if (dut.state_q[2][0] !== 2'b00) begin failures++; $display("FAIL s_inv_state got=%0h exp=0", dut.state_q[2][0]); end
        @(negedge CLK); #1;
        checks++; if (dut.state_q[2][0] !== 2'b00) begin failures++; $display("FAIL s_repeat_state got=%0h exp=0", dut.state_q[2][0]); end
        ccwait = 1'b0;
        // Snoop invalidate and local update to the same entry in one cycle.
        do_upd(3'd2, 1'b0, 26'h3, 2'b01);
        ccwait = 1'b1; ccinv = 1'b1;
        do_upd(3'd2, 1'b0, 26'h3, 2'b10);
        ccwait = 1'b0; ccinv = 1'b0; #1;
        checks++; if (dut.state_q[2][0] !== 2'b00) begin failures++; $display("FAIL conflict_state got=%0h exp=0", dut.state_q[2][0]); end
        // Both ways hold tag 7 at index 3: way 0 (S) must win, so no transfer.
        do_upd(3'd3, 1'b0, 26'h7, 2'b01);
        do_upd(3'd3, 1'b1, 26'h7, 2'b10);
        ccwait = 1'b1; ccsnoopaddr = 32'h1D8; #1;
        checks++; if (cctrans !== 1'b0) begin failures++; $display("FAIL dual_hit_cctrans got=%0h exp=0", cctrans); end
        @(negedge CLK);
        ccwait = 1'b0;
        do_upd(3'd3, 1'b1, 26'h0, 2'b00);
    endtask

    task automatic test_upd_during_wb;
        do_upd(3'd0, 1'b1, 26'h1, 2'b10);
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0; dwait = 1'b1;
        @(negedge CLK);
        ccwait = 1'b0;
        do_upd(3'd0, 1'b1, 26'h1, 2'b00);  // WB0: same entry, must be ignored
        do_upd(3'd1, 1'b0, 26'h5, 2'b01);  // WB0: other entry, applied
        #1;
        checks++; if (cctrans !== 1'b1) begin failures++; $display("FAIL upd_wb_cctrans got=%0h exp=1", cctrans); end
        checks++; if ({dut.state_q[1][0], dut.tag_q[1][0]} !== {2'b01, 26'h5}) begin
            failures++; $display("FAIL upd_other got=%0h/%0h exp=1/5", dut.state_q[1][0], dut.tag_q[1][0]); end
        dwait = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        dwait = 1'b1; #1;
        checks++; if (dut.state_q[0][1] !== 2'b01) begin failures++; $display("FAIL upd_same_state got=%0h exp=1", dut.state_q[0][1]); end
        checks++; if (snoop_busy !== 1'b0) begin failures++; $display("FAIL upd_idle_busy got=%0h exp=0", snoop_busy); end
    endtask

    task automatic test_reset_mid;
        do_upd(3'd0, 1'b1, 26'h1, 2'b10);
        ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0; dwait = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        dwait = 1'b1; #1;
        checks++; if (snoop_daddr !== 32'h44) begin failures++; $display("FAIL mid_wb1_daddr got=%0h exp=44", snoop_daddr); end
        nRST = 1'b0; #1;
        checks++; if ({cctrans, snoop_busy} !== 2'b00) begin failures++; $display("FAIL mid_rst_ctl got=%0b exp=00", {cctrans, snoop_busy}); end
        checks++; if ({snoop_daddr, snoop_dstore, rd_index, rd_way, rd_blkoff} !== '0) begin
            failures++; $display("FAIL mid_rst_outs got=%0h/%0h exp=0", snoop_daddr, snoop_dstore); end
        checks++; if ({dut.state_q[0][1], dut.state_q[1][0]} !== 4'b0) begin
            failures++; $display("FAIL mid_rst_lines got=%0h/%0h exp=0", dut.state_q[0][1], dut.state_q[1][0]); end
        @(negedge CLK);
        nRST = 1'b1; #1;
        checks++; if ({cctrans, snoop_busy} !== 2'b01) begin failures++; $display("FAIL post_rst got=%0b exp=01", {cctrans, snoop_busy}); end
        @(negedge CLK);
        ccwait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_writeback(1'b0, 2'b01);
        test_writeback(1'b1, 2'b00);
        test_s_invalidate();
        test_upd_during_wb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_snoop_responder.md
Name: dcache_snoop_responder

Overview:
- Cache-side end of the coherence bus; one instance per CPU's dcache.
- Holds a mirror of the dcache tags and MSI state.
- Answers snoops from memory_control: asserts cctrans on a Modified hit, then supplies the dirty block word by word so the controller can forward it to the requestor and write it back to RAM.
- Applies the resulting M->S or ->I downgrade, and signals snoop_busy so the local dcache FSM stalls.

Parameters:
- SETS, 8, number of sets; index width IW = log2(SETS) = 3.
- WAYS, 2, associativity; way select is 1 bit.
- TW, 26, tag width; address split is tag [31:6], index [5:3], blkoff [2], byte [1:0].

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- ccwait  in  1  high = snoop in progress targeting this cache.
- ccsnoopaddr  in  32  snooped address.
- ccinv  in  1  requestor is writing; invalidate the supplied/held line.
- dwait  in  1  low = current word accepted by RAM/controller.
- cctrans  out  1  Modified hit; this cache supplies the block.
- snoop_daddr  out  32  word address of the supplied word.
- snoop_dstore  out  32  data of the supplied word.
- snoop_busy  out  1  local dcache must stall (no fills, no hits).
- rd_index  out  IW  data-array read index.
- rd_way  out  1  data-array read way.
- rd_blkoff  out  1  data-array read word.
- rd_data  in  32  data-array word, combinational from rd_*.
- upd_en  in  1  local dcache writes a tag/state entry.
- upd_index  in  IW  entry index.
- upd_way  in  1  entry way.
- upd_tag  in  TW  entry tag.
- upd_state  in  2  new state: 00 = I, 01 = S, 10 = M (11 is treated as I).

Behaviour:
- Storage: tag[SETS][WAYS] and state[SETS][WAYS], flops.
  - Reset: all states I, tags 0.
- Hit logic (combinational): hit_way = way w with state != I and tag == ccsnoopaddr[31:6] at index ccsnoopaddr[5:3].
  - If both ways match, way 0 wins.
- FSM states: IDLE, WB0, WB1.
  - Registered at snoop accept: snp_index, snp_way, snp_tag, inv_seen.
- IDLE:
  - cctrans = ccwait && hit && state == M (combinational, same cycle).
  - On that condition: latch index/way/tag, set inv_seen = ccinv, go to WB0.
  - On ccwait && hit && state == S && ccinv: state -> I next cycle, cctrans = 0, stay in IDLE.
  - ccwait && S hit without ccinv: no action.
  - Miss: no action.
- WB0:
  - snoop_daddr = {snp_tag, snp_index, 1'b0, 2'b00}; rd_blkoff = 0; snoop_dstore = rd_data.
  - cctrans held at 1; inv_seen |= ccinv.
  - On !dwait: go to WB1.
- WB1:
  - Same as WB0 with blkoff = 1.
  - On !dwait: state[snp_index][snp_way] <= (inv_seen || ccinv) ? I : S; go to IDLE.
- rd_index / rd_way = snp_index / snp_way in WB0/WB1, 0 in IDLE.
- snoop_busy: high in WB0/WB1, and high in IDLE whenever ccwait = 1.
- Local update: upd_en writes tag and state at the next edge.
  - Exception: upd_en targeting {snp_index, snp_way} while in WB0/WB1 is ignored.
  - Same-cycle conflict in IDLE (S-invalidate plus upd_en to the same entry): the invalidate wins.
  - upd_en to a different entry is always honoured.
- dwait held high: remain in WB0/WB1 indefinitely, outputs stable.
- ccwait dropping mid-WB: ignored; writeback completes.
- Reset mid-operation: FSM to IDLE, all outputs 0, all lines I.
- Output reset values: cctrans 0, snoop_daddr 0, snoop_dstore 0, snoop_busy 0, rd_index 0, rd_way 0, rd_blkoff 0.
- Latency: cctrans in the same cycle as the snoop. Block transfer is 2 words, each word one or more cycles gated by dwait.
  - Minimum snoop-to-IDLE: 3 cycles.

Test Plan:
- Reset, then snoop 0x00000040 with ccwait = 1 -> cctrans = 0, snoop_busy = 1, no state change.
- upd index 0 / way 1 / tag 0x0000001 / M; snoop 0x00000040 (dwait: 2 cycles high, then low, then low) -> cctrans = 1.
  - WB0: daddr 0x40, dstore = word0; WB1: daddr 0x44, dstore = word1.
  - Final state S; IDLE after 4 cycles.
- Same as above with ccinv = 1 pulsed in WB1 only -> final state I; a later snoop 0x40 misses.
- Line S at index 2, tag 0x3; snoop 0x000000D0 with ccinv = 1 -> cctrans = 0, line becomes I next cycle.
  - Repeat snoop with ccinv = 0 -> no change.
- During WB0 of index 0 / way 1, upd_en to the same entry with state I -> ignored, writeback completes, state S.
  - upd_en to index 1 in the same cycle -> applied.
- nRST asserted in WB1 -> cctrans / snoop_busy drop to 0 immediately, all lines I, FSM in IDLE.
